// File: rtl/drum_sequencer_pkg.sv
// Shared constants, slot-sweep state encoding and pattern helpers for the drum sequencer.
package drum_sequencer_pkg;

  localparam int N_VOICES  = 3;
  localparam int STEPS     = 16;
  localparam int STEP_W    = 4;
  localparam int SEL_W     = 2;
  localparam int TEMPO_W   = 26;
  localparam int PAT_W     = N_VOICES * STEPS;
  localparam int PAT_IDX_W = $clog2(PAT_W);

  // Bit v*STEPS+s set means voice v fires on step s.
  localparam logic [PAT_W-1:0] PAT_INIT = 48'h5555_1010_0101;

  localparam int KICK  = 0;
  localparam int SNARE = 1;
  localparam int HAT   = 2;

  // One state per ROM slot; the slot order is the voice order.
  typedef enum logic [1:0] {
    SL_IDLE  = 2'd0,
    SL_KICK  = 2'd1,
    SL_SNARE = 2'd2,
    SL_HAT   = 2'd3
  } slot_state_t;

  // Gather the fire bits of every voice for one step.
  function automatic logic [N_VOICES-1:0] pattern_column(input logic [PAT_W-1:0]  pat,
                                                         input logic [STEP_W-1:0] s);
    logic [N_VOICES-1:0]  col;
    logic [PAT_IDX_W-1:0] idx;
    col = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      idx    = PAT_IDX_W'(v * STEPS) + PAT_IDX_W'(s);
      col[v] = pat[idx];
    end
    return col;
  endfunction

endpackage

// File: rtl/drum_sequencer_if.sv
// Control and output bundle between the user controls and the sequencer.
interface drum_sequencer_if;
  import drum_sequencer_pkg::*;

  logic                play;
  logic [TEMPO_W-1:0]  tempo_div;
  logic                pat_we;
  logic [SEL_W-1:0]    pat_voice;
  logic [STEP_W-1:0]   pat_step;
  logic                pat_bit;
  logic                sample_tick;
  logic                ovr_clr;

  logic [N_VOICES-1:0] go;
  logic [N_VOICES-1:0] en;
  logic [SEL_W-1:0]    rom_sel;
  logic                slot_valid;
  logic [STEP_W-1:0]   step;
  logic                beat;
  logic                tick_overrun;

  modport master (
    output play, tempo_div, pat_we, pat_voice, pat_step, pat_bit, sample_tick, ovr_clr,
    input  go, en, rom_sel, slot_valid, step, beat, tick_overrun
  );

  modport slave (
    input  play, tempo_div, pat_we, pat_voice, pat_step, pat_bit, sample_tick, ovr_clr,
    output go, en, rom_sel, slot_valid, step, beat, tick_overrun
  );

endinterface

// File: rtl/drum_sequencer_slot_scheduler.sv
// Round-robin ROM slot sweep: one en slot per voice after each accepted sample tick,
// with a sticky flag for ticks that land mid-sweep.
module drum_sequencer_slot_scheduler
  import drum_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                sample_tick,
  input  logic                ovr_clr,
  input  logic [N_VOICES-1:0] go_mask,
  output logic [N_VOICES-1:0] en,
  output logic [SEL_W-1:0]    rom_sel,
  output logic                slot_valid,
  output logic                tick_overrun
);

  slot_state_t         state;
  slot_state_t         state_nxt;
  logic                accept;
  logic                overrun_hit;
  logic [N_VOICES-1:0] en_d;
  logic [SEL_W-1:0]    sel_d;
  logic                valid_d;

  // Sweep state and registered slot outputs; a voice restarting this edge loses its
  // advance slot, but the slot itself is still reported as owned.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= SL_IDLE;
      en         <= '0;
      rom_sel    <= '0;
      slot_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      en         <= en_d & ~go_mask;
      rom_sel    <= sel_d;
      slot_valid <= valid_d;
    end
  end

  // Next sweep state: a tick restarts the sweep only from idle or from the last slot.
  always_comb begin
    accept      = sample_tick && (state == SL_IDLE || state == SL_HAT);
    overrun_hit = sample_tick && !accept;
    state_nxt   = SL_IDLE;
    if (accept) begin
      state_nxt = SL_KICK;
    end else begin
      case (state)
        SL_KICK:  state_nxt = SL_SNARE;
        SL_SNARE: state_nxt = SL_HAT;
        default:  state_nxt = SL_IDLE;
      endcase
    end
  end

  // Slot decode of the upcoming state, registered above.
  always_comb begin
    en_d    = '0;
    sel_d   = '0;
    valid_d = 1'b0;
    case (state_nxt)
      SL_KICK: begin
        en_d[KICK] = 1'b1;
        sel_d      = SEL_W'(KICK);
        valid_d    = 1'b1;
      end
      SL_SNARE: begin
        en_d[SNARE] = 1'b1;
        sel_d       = SEL_W'(SNARE);
        valid_d     = 1'b1;
      end
      SL_HAT: begin
        en_d[HAT] = 1'b1;
        sel_d     = SEL_W'(HAT);
        valid_d   = 1'b1;
      end
      default: begin
        en_d    = '0;
        sel_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Sticky overrun flag; a new overrun wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_overrun <= 1'b0;
    end else if (overrun_hit) begin
      tick_overrun <= 1'b1;
    end else if (ovr_clr) begin
      tick_overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/drum_sequencer.sv
// 16-step, 3-voice drum pattern sequencer: tempo divider, step counter, pattern store,
// go/beat pulse generation, and the shared-ROM slot scheduler.
module drum_sequencer
  import drum_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  drum_sequencer_if.slave  ctl
);

  logic [PAT_W-1:0]     pattern;
  logic [TEMPO_W-1:0]   div_cnt;
  logic [TEMPO_W-1:0]   div_nxt;
  logic [TEMPO_W-1:0]   div_max;
  logic [STEP_W-1:0]    step_q;
  logic [STEP_W-1:0]    step_nxt;
  logic                 play_d;
  logic                 play_rise;
  logic                 step_hit;
  logic                 beat_q;
  logic                 beat_nxt;
  logic [N_VOICES-1:0]  go_q;
  logic [N_VOICES-1:0]  go_nxt;
  logic                 pat_wr;
  logic [PAT_IDX_W-1:0] pat_idx;

  // A tempo of 0 runs one step per cycle. The compare is >= so that shrinking tempo_div
  // below the running count fires at the next compare instead of wrapping the counter.
  assign div_max   = (ctl.tempo_div == '0) ? TEMPO_W'(1) : ctl.tempo_div;
  assign play_rise = ctl.play & ~play_d;
  assign step_hit  = ctl.play & (div_cnt >= div_max - TEMPO_W'(1));
  assign pat_wr    = ctl.pat_we & (ctl.pat_voice < SEL_W'(N_VOICES));
  assign pat_idx   = PAT_IDX_W'(ctl.pat_voice) * PAT_IDX_W'(STEPS) + PAT_IDX_W'(ctl.pat_step);

  // Step sequencing: restart on play rise, advance on divider compare, hold while paused.
  // go reads the pattern register before any same-cycle write lands.
  always_comb begin
    step_nxt = step_q;
    div_nxt  = div_cnt;
    go_nxt   = '0;
    beat_nxt = 1'b0;
    if (play_rise) begin
      step_nxt = '0;
      div_nxt  = '0;
      go_nxt   = pattern_column(pattern, '0);
      beat_nxt = 1'b1;
    end else if (step_hit) begin
      step_nxt = step_q + STEP_W'(1);
      div_nxt  = '0;
      go_nxt   = pattern_column(pattern, step_nxt);
      beat_nxt = (step_nxt == '0);
    end else if (ctl.play) begin
      div_nxt  = div_cnt + TEMPO_W'(1);
    end
  end

  // Step/tempo state and the registered go/beat pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      play_d  <= 1'b0;
      step_q  <= '0;
      div_cnt <= '0;
      go_q    <= '0;
      beat_q  <= 1'b0;
    end else begin
      play_d  <= ctl.play;
      step_q  <= step_nxt;
      div_cnt <= div_nxt;
      go_q    <= go_nxt;
      beat_q  <= beat_nxt;
    end
  end

  // Pattern store; writes to voices beyond the last one are dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pattern <= PAT_INIT;
    end else if (pat_wr) begin
      pattern[pat_idx] <= ctl.pat_bit;
    end
  end

  assign ctl.go   = go_q;
  assign ctl.step = step_q;
  assign ctl.beat = beat_q;

  drum_sequencer_slot_scheduler u_slots (
    .clk          (clk),
    .resetn       (resetn),
    .sample_tick  (ctl.sample_tick),
    .ovr_clr      (ctl.ovr_clr),
    .go_mask      (go_nxt),
    .en           (ctl.en),
    .rom_sel      (ctl.rom_sel),
    .slot_valid   (ctl.slot_valid),
    .tick_overrun (ctl.tick_overrun)
  );

endmodule

// File: tb/tb_drum_sequencer.sv
// Vector-table bench for drum_sequencer with an expected-result queue and a few
// hand-written reset sequences.
module tb_drum_sequencer;
  import drum_sequencer_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  drum_sequencer_if bus_if ();

  drum_sequencer dut (
    .clk    (clk),
    .resetn (resetn),
    .ctl    (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        play;
    logic [7:0]  tdiv;
    logic        we;
    logic [1:0]  voice;
    logic [3:0]  stp;
    logic        pbit;
    logic        tick;
    logic        clr;
    logic [14:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [14:0] exp;
  } sb_t;

  vec_t        tbl[$];
  sb_t         sbq[$];
  sb_t         cur;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [14:0] act;

  assign act = {bus_if.go, bus_if.en, bus_if.rom_sel, bus_if.slot_valid,
                bus_if.step, bus_if.beat, bus_if.tick_overrun};

  function automatic logic [14:0] pk(int go, int en, int sel, int sv, int st, int beat, int ovr);
    return {3'(go), 3'(en), 2'(sel), 1'(sv), 4'(st), 1'(beat), 1'(ovr)};
  endfunction

  function automatic vec_t mkv(int play, int tdiv, int we, int voice, int stp, int pbit,
                               int tick, int clr, logic [14:0] e);
    vec_t v;
    v.play  = 1'(play);
    v.tdiv  = 8'(tdiv);
    v.we    = 1'(we);
    v.voice = 2'(voice);
    v.stp   = 4'(stp);
    v.pbit  = 1'(pbit);
    v.tick  = 1'(tick);
    v.clr   = 1'(clr);
    v.exp   = e;
    return v;
  endfunction

  function automatic string fmt(logic [14:0] x);
    return $sformatf("go=%b en=%b sel=%0d sv=%b step=%0d beat=%b ovr=%b",
                     x[14:12], x[11:9], x[8:7], x[6], x[5:2], x[1], x[0]);
  endfunction

  task automatic check(input string name, input logic [14:0] a, input logic [14:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got {%s} expected {%s}", name, fmt(a), fmt(e));
    end
  endtask

  task automatic add(int play, int tdiv, int we, int voice, int stp, int pbit,
                     int tick, int clr, logic [14:0] e);
    tbl.push_back(mkv(play, tdiv, we, voice, stp, pbit, tick, clr, e));
  endtask

  // Drive one vector half a cycle before the edge and queue what must appear after it.
  task automatic apply(input vec_t v, input string name);
    sb_t s;
    @(negedge clk);
    #1;
    bus_if.play        = v.play;
    bus_if.tempo_div   = TEMPO_W'(v.tdiv);
    bus_if.pat_we      = v.we;
    bus_if.pat_voice   = v.voice;
    bus_if.pat_step    = v.stp;
    bus_if.pat_bit     = v.pbit;
    bus_if.sample_tick = v.tick;
    bus_if.ovr_clr     = v.clr;
    s.name = name;
    s.exp  = v.exp;
    sbq.push_back(s);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sbq.size() > 0 && guard < 8) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (sbq.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d results still pending, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  // Pop and compare one expected result per clock, on the falling edge.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      cur = sbq.pop_front();
      check(cur.name, act, cur.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] pat_ref;
    logic [47:0] sh;
    int          s;

    pat_ref = 48'h5555_1010_0101;
    bus_if.play        = 1'b0;
    bus_if.tempo_div   = '0;
    bus_if.pat_we      = 1'b0;
    bus_if.pat_voice   = '0;
    bus_if.pat_step    = '0;
    bus_if.pat_bit     = 1'b0;
    bus_if.sample_tick = 1'b0;
    bus_if.ovr_clr     = 1'b0;

    // tempo_div=4 from reset: play rise fires step 0, then a step every 4 cycles
    add(1,4,0,0,0,0,0,0, pk(5,0,0,0,0,1,0));
    for (int i = 0; i < 3; i++) add(1,4,0,0,0,0,0,0, pk(0,0,0,0,0,0,0));
    add(1,4,0,0,0,0,0,0, pk(0,0,0,0,1,0,0));
    for (int i = 0; i < 3; i++) add(1,4,0,0,0,0,0,0, pk(0,0,0,0,1,0,0));
    add(1,4,0,0,0,0,0,0, pk(4,0,0,0,2,0,0));
    for (int i = 0; i < 3; i++) add(1,4,0,0,0,0,0,0, pk(0,0,0,0,2,0,0));
    add(1,4,0,0,0,0,0,0, pk(0,0,0,0,3,0,0));
    for (int i = 0; i < 3; i++) add(1,4,0,0,0,0,0,0, pk(0,0,0,0,3,0,0));
    add(1,4,0,0,0,0,0,0, pk(6,0,0,0,4,0,0));
    add(0,4,0,0,0,0,0,0, pk(0,0,0,0,4,0,0));

    // tempo_div=0: restart then one step per cycle through the wrap back to 0
    for (int k = 0; k <= 16; k++) begin
      s  = k % 16;
      sh = pat_ref >> s;
      add(1,0,0,0,0,0,0,0, pk(int'({sh[32], sh[16], sh[0]}), 0, 0, 0, s, (s == 0) ? 1 : 0, 0));
    end

    // slot sweep, mid-sweep tick, overrun clear, set-beats-clear
    add(0,0,0,0,0,0,1,0, pk(0,1,0,1,0,0,0));
    add(0,0,0,0,0,0,0,0, pk(0,2,1,1,0,0,0));
    add(0,0,0,0,0,0,1,0, pk(0,4,2,1,0,0,1));
    add(0,0,0,0,0,0,0,0, pk(0,0,0,0,0,0,1));
    add(0,0,0,0,0,0,0,0, pk(0,0,0,0,0,0,1));
    add(0,0,0,0,0,0,0,1, pk(0,0,0,0,0,0,0));
    add(0,0,0,0,0,0,1,0, pk(0,1,0,1,0,0,0));
    add(0,0,0,0,0,0,1,1, pk(0,2,1,1,0,0,1));
    add(0,0,0,0,0,0,0,1, pk(0,4,2,1,0,0,0));
    add(0,0,0,0,0,0,0,0, pk(0,0,0,0,0,0,0));

    // ticks every 3 cycles, accepted in the last slot: back-to-back sweeps
    for (int i = 0; i < 9; i++)
      add(0,0,0,0,0,0,(i % 3 == 0) ? 1 : 0,0, pk(0, 1 << (i % 3), i % 3, 1, 0, 0, 0));
    add(0,0,0,0,0,0,0,0, pk(0,0,0,0,0,0,0));

    // pattern write ahead of the step, then the same write in the fire cycle, then collision
    add(1,2,0,0,0,0,0,0, pk(5,0,0,0,0,1,0));
    add(1,2,0,0,0,0,0,0, pk(0,0,0,0,0,0,0));
    add(1,2,0,0,0,0,0,0, pk(0,0,0,0,1,0,0));
    add(1,2,0,0,0,0,0,0, pk(0,0,0,0,1,0,0));
    add(1,2,0,0,0,0,0,0, pk(4,0,0,0,2,0,0));
    add(1,2,1,1,3,1,0,0, pk(0,0,0,0,2,0,0));
    add(1,2,0,0,0,0,0,0, pk(2,0,0,0,3,0,0));
    add(1,2,1,1,3,0,0,0, pk(0,0,0,0,3,0,0));
    add(0,2,0,0,0,0,0,0, pk(0,0,0,0,3,0,0));
    add(1,2,0,0,0,0,0,0, pk(5,0,0,0,0,1,0));
    add(1,2,0,0,0,0,0,0, pk(0,0,0,0,0,0,0));
    add(1,2,0,0,0,0,0,0, pk(0,0,0,0,1,0,0));
    add(1,2,0,0,0,0,0,0, pk(0,0,0,0,1,0,0));
    add(1,2,0,0,0,0,0,0, pk(4,0,0,0,2,0,0));
    add(1,2,0,0,0,0,0,0, pk(0,0,0,0,2,0,0));
    add(1,2,1,1,3,1,0,0, pk(0,0,0,0,3,0,0));
    add(1,2,0,0,0,0,1,0, pk(0,1,0,1,3,0,0));
    add(1,2,0,0,0,0,0,0, pk(6,0,1,1,4,0,0));
    add(1,2,0,0,0,0,0,0, pk(0,4,2,1,4,0,0));
    add(1,2,0,0,0,0,0,0, pk(0,0,0,0,5,0,0));
    add(0,2,0,0,0,0,0,0, pk(0,0,0,0,5,0,0));

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", act, '0);
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));
    drain();

    // asynchronous reset in the middle of a sweep and a step
    apply(mkv(0,2,0,0,0,0,1,0, pk(0,1,0,1,5,0,0)), "rst_tick");
    apply(mkv(0,2,0,0,0,0,0,0, pk(0,2,1,1,5,0,0)), "rst_slot1");
    drain();
    #2;
    resetn = 1'b0;
    #1;
    check("rst_async", act, '0);
    @(negedge clk);
    #1;
    check("rst_held", act, '0);
    resetn = 1'b1;

    // no leftover slot pulses, and the pattern is back to its reset contents
    apply(mkv(0,1,0,0,0,0,0,0, pk(0,0,0,0,0,0,0)), "post_rst0");
    apply(mkv(0,1,0,0,0,0,0,0, pk(0,0,0,0,0,0,0)), "post_rst1");
    apply(mkv(1,1,0,0,0,0,0,0, pk(5,0,0,0,0,1,0)), "post_step0");
    apply(mkv(1,1,0,0,0,0,0,0, pk(0,0,0,0,1,0,0)), "post_step1");
    apply(mkv(1,1,0,0,0,0,0,0, pk(4,0,0,0,2,0,0)), "post_step2");
    apply(mkv(1,1,0,0,0,0,0,0, pk(0,0,0,0,3,0,0)), "post_step3");
    apply(mkv(1,1,0,0,0,0,0,0, pk(6,0,0,0,4,0,0)), "post_step4");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
